instr_loader: RTL and testbench

Program loader for the jacaranda-8 charlatan core: it receives a framed program image over a byte-stream valid/ready interface and writes it into the 256 x 8 instruction memory through a synchronous write port. While loading it holds the CPU and reports completion or error. It is the write-side counterpart of the instruction memory's combinational read port, and sits between the host byte source (UART receiver) and the instruction memory.

---
 rtl/instr_loader.sv | 200 ++++++++++++++++++++
 tb/tb_instr_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: receives a framed program image (SYNC, LEN, payload, CSUM)
// over a byte-stream valid/ready link and writes the payload into the
// 256 x 8 instruction memory, holding the CPU while the load is in progress.
module instr_loader #(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // A frame is good when payload sum plus checksum byte is zero mod 256.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = 8'(sum + csum);
        return (total == 8'h00);
    endfunction

    state_t      state_q, state_d;
    logic [8:0]  remain_q, remain_d;     // payload bytes still expected (1..256)
    logic [7:0]  offset_q, offset_d;     // write offset from BASE_ADDR, wraps mod 256
    logic [7:0]  sum_q, sum_d;           // running payload sum mod 256
    logic [15:0] tmo_q, tmo_d;           // cycles since last accepted byte
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;         // also drives rx_ready: both mean "in a frame"

    logic        accept_s;
    logic [15:0] tmo_inc_s;
    logic        tmo_fire_s;

    assign accept_s   = rx_valid & busy_q;
    assign tmo_inc_s  = tmo_q + 16'd1;
    assign tmo_fire_s = (TIMEOUT != 16'd0) && (tmo_inc_s == TIMEOUT);

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        offset_d   = offset_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SYNC;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_hold_d = 1'b1;
                    tmo_d      = 16'd0;
                end else begin
                    tmo_d = 16'd0;
                end
            end
            ST_SYNC: begin
                // Hunting for the marker never times out; counter stays cleared
                // so LEN starts with a fresh window.
                tmo_d = 16'd0;
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    remain_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    sum_d    = 8'h00;
                    offset_d = 8'h00;
                    tmo_d    = 16'd0;
                    state_d  = ST_DATA;
                end else if (tmo_fire_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 16'd0;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 8'(BASE_ADDR + offset_q);
                    wr_data_d = rx_data;
                    sum_d     = 8'(sum_q + rx_data);
                    offset_d  = 8'(offset_q + 8'd1);
                    remain_d  = remain_q - 9'd1;
                    tmo_d     = 16'd0;
                    if (remain_q == 9'd1) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (tmo_fire_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 16'd0;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    state_d = ST_IDLE;
                    tmo_d   = 16'd0;
                    if (csum_ok(sum_q, rx_data)) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_fire_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 16'd0;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = 16'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output update; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            remain_q   <= 9'd0;
            offset_q   <= 8'h00;
            sum_q      <= 8'h00;
            tmo_q      <= 16'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            offset_q   <= offset_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready = busy_q;
    assign busy     = busy_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: randomized framed images checked by a
// scoreboard (expected writes and frame outcomes queued by the stimulus,
// consumed by an independent monitor).
module tb_instr_loader;

    localparam logic [7:0]  BASE = 8'h10;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [15:0] TMO  = 16'd20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready, wr_en, cpu_hold, busy, done, err;
    logic [7:0] wr_addr, wr_data;

    instr_loader #(.BASE_ADDR(BASE), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic dn; logic er; logic hd; } res_t;

    wr_t        exp_wr[$];
    res_t       exp_res[$];
    logic [7:0] pre_q[$];
    logic [7:0] pl_q[$];

    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int cyc = 0;
    logic prev_busy = 1'b0;
    wr_t  mw;
    res_t mr;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: pops expected writes and frame outcomes as the DUT presents them.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
        end else begin
            if (wr_en) begin
                n_writes++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mw = exp_wr.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(mw.a));
                    chk("wr_data", int'(wr_data), int'(mw.d));
                end
            end
            if (prev_busy && !busy) begin
                chk("writes_pending_at_end", exp_wr.size(), 0);
                if (exp_res.size() == 0) begin
                    chk("unexpected_frame_end", 1, 0);
                end else begin
                    mr = exp_res.pop_front();
                    chk("done", int'(done), int'(mr.dn));
                    chk("err", int'(err), int'(mr.er));
                    chk("cpu_hold", int'(cpu_hold), int'(mr.hd));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one byte (after an optional random idle gap) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        bit acc;
        acc = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int n = 0; n < 64; n++) begin
            acc = rx_ready;
            tick();
            if (acc) break;
        end
        if (!acc) chk("byte_accept_timeout", 0, 1);
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] good_csum();
        int s;
        s = 0;
        foreach (pl_q[i]) s += int'(pl_q[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full frame: start, pre_q garbage, SYNC, LEN, pl_q payload, csum.
    task automatic do_frame(input logic [7:0] csum, input int gap_max,
                            input int idle_before, input bit mid_start);
        int s;
        res_t r;
        wr_t w;
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        chk("rx_ready_after_start", int'(rx_ready), 1);
        chk("done_cleared", int'(done), 0);
        chk("err_cleared", int'(err), 0);
        chk("hold_on_start", int'(cpu_hold), 1);
        repeat (idle_before) tick();
        foreach (pre_q[i]) send_byte(pre_q[i], gap_max);
        send_byte(SYNC, gap_max);
        send_byte(8'(pl_q.size()), gap_max);
        s = 0;
        foreach (pl_q[i]) begin
            w.a = 8'((int'(BASE) + i) % 256);
            w.d = pl_q[i];
            exp_wr.push_back(w);
            s += int'(pl_q[i]);
            if (mid_start && i == pl_q.size() / 2) start = 1'b1;
            send_byte(pl_q[i], gap_max);
            start = 1'b0;
        end
        r.dn = (((s + int'(csum)) % 256) == 0);
        r.er = !r.dn;
        r.hd = !r.dn;
        exp_res.push_back(r);
        send_byte(csum, gap_max);
        chk("busy_after_csum", int'(busy), 0);
    endtask

    initial begin
        int t0, w0;
        logic [7:0] b;

        // Reset values.
        repeat (3) @(negedge clock);
        chk("rst_rx_ready", int'(rx_ready), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();

        // Good frame, back to back.
        pre_q = {};
        pl_q = {8'h11, 8'h22, 8'h33};
        do_frame(8'h9A, 0, 0, 1'b0);
        tick();

        // Bad checksum, then a good frame recovers.
        pl_q = {8'h01, 8'h02};
        do_frame(8'h00, 0, 0, 1'b0);
        tick();
        pl_q = {8'h5A, 8'hC3, 8'h07, 8'h99};
        do_frame(good_csum(), 1, 0, 1'b0);
        tick();

        // Sync hunt, with a long idle in SYNC (timeout must not apply there).
        pre_q = {8'h00, 8'hFF};
        pl_q = {8'h7E};
        do_frame(8'h82, 0, 40, 1'b0);
        pre_q = {};
        tick();

        // LEN = 0: 256 bytes, address wrap, no bubbles.
        pl_q = {};
        for (int i = 0; i < 256; i++) pl_q.push_back(8'(i));
        pulse_start();
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        t0 = cyc;
        foreach (pl_q[i]) begin
            mw.a = 8'((int'(BASE) + i) % 256);
            mw.d = pl_q[i];
            exp_wr.push_back(mw);
            send_byte(pl_q[i], 0);
        end
        mr.dn = 1'b1; mr.er = 1'b0; mr.hd = 1'b0;
        exp_res.push_back(mr);
        send_byte(8'h80, 0);
        chk("len0_cycles_no_bubbles", cyc - t0, 257);
        chk("len0_busy_low", int'(busy), 0);
        tick();

        // Timeout after one payload byte.
        pulse_start();
        send_byte(SYNC, 0);
        send_byte(8'h04, 0);
        w0 = n_writes;
        mw.a = BASE; mw.d = 8'hAA;
        exp_wr.push_back(mw);
        mr.dn = 1'b0; mr.er = 1'b1; mr.hd = 1'b1;
        exp_res.push_back(mr);
        send_byte(8'hAA, 0);
        repeat (19) tick();
        chk("tmo_err_not_yet", int'(err), 0);
        chk("tmo_busy_not_yet", int'(busy), 1);
        tick();
        chk("tmo_err", int'(err), 1);
        chk("tmo_busy", int'(busy), 0);
        tick();
        chk("tmo_one_write", n_writes - w0, 1);
        chk("tmo_hold_kept", int'(cpu_hold), 1);

        // Reset mid-DATA after two payload bytes.
        pulse_start();
        send_byte(SYNC, 0);
        send_byte(8'h05, 0);
        w0 = n_writes;
        for (int i = 0; i < 2; i++) begin
            mw.a = 8'(BASE + 8'(i)); mw.d = 8'(8'h30 + 8'(i));
            exp_wr.push_back(mw);
            send_byte(mw.d, 0);
        end
        tick();
        chk("pre_reset_writes", n_writes - w0, 2);
        reset_n = 1'b0;
        #1;
        exp_wr.delete();
        chk("mid_rst_rx_ready", int'(rx_ready), 0);
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_wr_addr", int'(wr_addr), 0);
        chk("mid_rst_wr_data", int'(wr_data), 0);
        chk("mid_rst_cpu_hold", int'(cpu_hold), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Randomized frames, some with start pulsed mid-frame.
        for (int f = 0; f < 20; f++) begin
            pre_q = {};
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                pre_q.push_back(b);
            end
            pl_q = {};
            repeat ($urandom_range(1, 40)) pl_q.push_back(8'($urandom));
            b = good_csum();
            if ($urandom_range(0, 3) == 0) b = 8'(b + 8'($urandom_range(1, 255)));
            do_frame(b, 3, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_res_drained", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
